// File: rtl/motor_pid_ctrl_if.sv
// Sample/gain/duty bundle between the RPM measurement stage, the PID
// controller and the PWM stage.
interface motor_pid_ctrl_if #(
  parameter int DUTY_WIDTH = 12
);
  logic                  enable_i;
  logic                  rpm_valid_i;
  logic [31:0]           rpm_data_i;
  logic [15:0]           target_rpm_i;
  logic [15:0]           kp_i;
  logic [15:0]           ki_i;
  logic [15:0]           kd_i;
  logic                  busy_o;
  logic                  duty_valid_o;
  logic [DUTY_WIDTH-1:0] duty_o;

  modport master (
    output enable_i, rpm_valid_i, rpm_data_i, target_rpm_i, kp_i, ki_i, kd_i,
    input  busy_o, duty_valid_o, duty_o
  );

  modport slave (
    input  enable_i, rpm_valid_i, rpm_data_i, target_rpm_i, kp_i, ki_i, kd_i,
    output busy_o, duty_valid_o, duty_o
  );
endinterface

// File: rtl/motor_pid_ctrl.sv
// Sequential PID speed controller: one sample in, three multiply-accumulate
// steps on a shared multiplier, one saturated duty word out.
module motor_pid_ctrl #(
  parameter int DUTY_WIDTH = 12,
  parameter int FRAC_BITS  = 8,
  parameter int INT_LIMIT  = 1048576
) (
  input logic             clk,
  input logic             rstn,
  motor_pid_ctrl_if.slave pid
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ERR   = 3'd1;
  localparam logic [2:0] S_MUL_P = 3'd2;
  localparam logic [2:0] S_MUL_I = 3'd3;
  localparam logic [2:0] S_MUL_D = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;

  localparam logic signed [51:0] DUTY_MAX_S = 52'((64'd1 << DUTY_WIDTH) - 64'd1);
  localparam logic signed [32:0] INT_HI     = 33'(INT_LIMIT);
  localparam logic signed [32:0] INT_LO     = -INT_HI;

  logic [2:0]             state_reg, state_next;
  logic [15:0]            meas_reg, target_reg;
  logic [15:0]            gain_in  [3];
  logic [15:0]            gain_reg [3];
  logic signed [16:0]     e_reg, e_prev_reg;
  logic signed [17:0]     d_reg;
  logic signed [31:0]     int_reg;
  logic signed [51:0]     acc_reg;
  logic [DUTY_WIDTH-1:0]  duty_reg;
  logic                   duty_valid_reg;

  logic                   accept;
  logic [15:0]            meas_clip;
  logic signed [16:0]     e_now;
  logic signed [17:0]     d_now;
  logic signed [32:0]     int_sum;
  logic signed [31:0]     int_clamped;
  logic signed [16:0]     mul_a;
  logic signed [31:0]     mul_b;
  logic signed [48:0]     prod;
  logic signed [51:0]     y;
  logic [DUTY_WIDTH-1:0]  duty_sat;

  // OUT also accepts, so a strobe landing on the output edge starts the next update
  assign accept    = pid.enable_i && pid.rpm_valid_i &&
                     (state_reg == S_IDLE || state_reg == S_OUT);
  assign meas_clip = (pid.rpm_data_i > 32'd65535) ? 16'hFFFF : pid.rpm_data_i[15:0];

  assign gain_in[0] = pid.kp_i;
  assign gain_in[1] = pid.ki_i;
  assign gain_in[2] = pid.kd_i;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_gain
      logic [15:0] gain_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       gain_q <= '0;
        else if (accept) gain_q <= gain_in[gi];
      end
      assign gain_reg[gi] = gain_q;
    end
  endgenerate

  assign e_now   = $signed({1'b0, target_reg}) - $signed({1'b0, meas_reg});
  assign d_now   = 18'(e_now) - 18'(e_prev_reg);
  assign int_sum = 33'(int_reg) + 33'(e_now);

  always_comb begin
    int_clamped = int_sum[31:0];
    if (int_sum > INT_HI)      int_clamped = INT_HI[31:0];
    else if (int_sum < INT_LO) int_clamped = INT_LO[31:0];
  end

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      S_MUL_P: begin mul_a = $signed({1'b0, gain_reg[0]}); mul_b = 32'(e_reg); end
      S_MUL_I: begin mul_a = $signed({1'b0, gain_reg[1]}); mul_b = int_reg;    end
      S_MUL_D: begin mul_a = $signed({1'b0, gain_reg[2]}); mul_b = 32'(d_reg); end
      default: ;
    endcase
  end

  assign prod = 49'(mul_a) * 49'(mul_b);
  assign y    = acc_reg >>> FRAC_BITS;

  always_comb begin
    duty_sat = y[DUTY_WIDTH-1:0];
    if (y < 0)               duty_sat = '0;
    else if (y > DUTY_MAX_S) duty_sat = '1;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept) state_next = S_ERR;
      S_ERR:   state_next = S_MUL_P;
      S_MUL_P: state_next = S_MUL_I;
      S_MUL_I: state_next = S_MUL_D;
      S_MUL_D: state_next = S_OUT;
      S_OUT:   state_next = accept ? S_ERR : S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (!pid.enable_i) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= S_IDLE;
      meas_reg       <= '0;
      target_reg     <= '0;
      e_reg          <= '0;
      e_prev_reg     <= '0;
      d_reg          <= '0;
      int_reg        <= '0;
      acc_reg        <= '0;
      duty_reg       <= '0;
      duty_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      duty_valid_reg <= 1'b0;
      if (!pid.enable_i) begin
        // Disable aborts any update and returns the loop to its post-reset history
        int_reg    <= '0;
        e_prev_reg <= '0;
        acc_reg    <= '0;
        duty_reg   <= '0;
      end else begin
        if (accept) begin
          meas_reg   <= meas_clip;
          target_reg <= pid.target_rpm_i;
        end
        case (state_reg)
          S_ERR: begin
            e_reg      <= e_now;
            d_reg      <= d_now;
            int_reg    <= int_clamped;
            e_prev_reg <= e_now;
            acc_reg    <= '0;
          end
          S_MUL_P, S_MUL_I, S_MUL_D: acc_reg <= acc_reg + 52'(prod);
          S_OUT: begin
            duty_reg       <= duty_sat;
            duty_valid_reg <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign pid.busy_o       = (state_reg != S_IDLE);
  assign pid.duty_valid_o = duty_valid_reg;
  assign pid.duty_o       = duty_reg;
endmodule

// File: tb/tb_motor_pid_ctrl.sv
// Self-checking bench for motor_pid_ctrl: a vector table, hand-written timing
// sequences and randomized samples against a plain-arithmetic PID model.
module tb_motor_pid_ctrl;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  motor_pid_ctrl_if #(.DUTY_WIDTH(12)) bus ();
  motor_pid_ctrl_if #(.DUTY_WIDTH(12)) bus_lim ();

  assign bus_lim.enable_i     = bus.enable_i;
  assign bus_lim.rpm_valid_i  = bus.rpm_valid_i;
  assign bus_lim.rpm_data_i   = bus.rpm_data_i;
  assign bus_lim.target_rpm_i = bus.target_rpm_i;
  assign bus_lim.kp_i         = bus.kp_i;
  assign bus_lim.ki_i         = bus.ki_i;
  assign bus_lim.kd_i         = bus.kd_i;

  motor_pid_ctrl #(.DUTY_WIDTH(12), .FRAC_BITS(8), .INT_LIMIT(1048576)) dut (
    .clk(clk), .rstn(rstn), .pid(bus)
  );
  motor_pid_ctrl #(.DUTY_WIDTH(12), .FRAC_BITS(8), .INT_LIMIT(250)) dut_lim (
    .clk(clk), .rstn(rstn), .pid(bus_lim)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst;
    logic [31:0] rpm;
    logic [15:0] tgt;
    logic [15:0] kp;
    logic [15:0] ki;
    logic [15:0] kd;
    int          exp0;
    int          exp1;
  } vec_t;
  vec_t vecs [14];

  longint m_eprev;
  longint m_i [2];

  task automatic check(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference PID: plain integer arithmetic on the update rules
  function automatic void model_step(input longint rpm, input longint tgt,
                                     input longint kp, input longint ki,
                                     input longint kd, output longint y0,
                                     output longint y1);
    longint lims [2];
    longint meas, e, d, acc, y;
    longint res [2];
    lims[0] = 1048576;
    lims[1] = 250;
    meas = (rpm > 65535) ? 65535 : rpm;
    e = tgt - meas;
    d = e - m_eprev;
    m_eprev = e;
    for (int j = 0; j < 2; j++) begin
      m_i[j] = m_i[j] + e;
      if (m_i[j] > lims[j])  m_i[j] = lims[j];
      if (m_i[j] < -lims[j]) m_i[j] = -lims[j];
      acc = kp * e + ki * m_i[j] + kd * d;
      y = acc >>> 8;
      res[j] = (y < 0) ? 0 : ((y > 4095) ? 4095 : y);
    end
    y0 = res[0];
    y1 = res[1];
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    bus.enable_i = 1'b1;
    bus.rpm_valid_i = 1'b0;
    bus.rpm_data_i = '0;
    bus.target_rpm_i = '0;
    bus.kp_i = '0;
    bus.ki_i = '0;
    bus.kd_i = '0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_eprev = 0;
    m_i[0] = 0;
    m_i[1] = 0;
  endtask

  // Called at a negedge; returns at the negedge after the sampling edge E
  task automatic send(input logic [31:0] rpm, input logic [15:0] tgt,
                      input logic [15:0] kp, input logic [15:0] ki,
                      input logic [15:0] kd);
    bus.rpm_data_i = rpm;
    bus.target_rpm_i = tgt;
    bus.kp_i = kp;
    bus.ki_i = ki;
    bus.kd_i = kd;
    bus.rpm_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rpm_valid_i = 1'b0;
  endtask

  task automatic wait_strobe(input string name, output logic [11:0] d0,
                             output logic [11:0] d1);
    int lat;
    lat = -1;
    d0 = '0;
    d1 = '0;
    check({name, " busy@E"}, bus.busy_o, 1);
    for (int k = 1; k <= 12 && lat < 0; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.duty_valid_o) begin
        lat = k;
        d0 = bus.duty_o;
        d1 = bus_lim.duty_o;
        check({name, " busy after out"}, bus.busy_o, 0);
        check({name, " lim strobe"}, bus_lim.duty_valid_o, 1);
      end else if (k <= 4) begin
        check($sformatf("%s busy@E+%0d", name, k), bus.busy_o, 1);
      end
    end
    check({name, " latency"}, lat, 5);
    if (lat > 0) begin
      @(posedge clk);
      @(negedge clk);
      check({name, " pulse width"}, bus.duty_valid_o, 0);
    end
  endtask

  task automatic count_strobes(input int n, output int cnt, output int first_k,
                               output logic [11:0] first_d);
    cnt = 0;
    first_k = -1;
    first_d = '0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.duty_valid_o) begin
        cnt++;
        if (first_k < 0) begin
          first_k = k;
          first_d = bus.duty_o;
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] d0, d1, fd;
    int cnt, fk;
    longint y0, y1;
    logic [31:0] rpm;
    logic [15:0] tgt, kp, ki, kd;

    vecs[0]  = '{1, 32'd400,     16'd1000,  16'h0100, 16'h0000, 16'h0000, 600, 600};
    vecs[1]  = '{1, 32'd0,       16'd5000,  16'h0100, 16'h0000, 16'h0000, 4095, 4095};
    vecs[2]  = '{1, 32'd500,     16'd100,   16'h0100, 16'h0000, 16'h0000, 0, 0};
    vecs[3]  = '{1, 32'h10000,   16'd0,     16'h0100, 16'h0000, 16'h0000, 0, 0};
    vecs[4]  = '{1, 32'h10064,   16'd65535, 16'h0000, 16'h0100, 16'h0000, 0, 0};
    vecs[5]  = '{0, 32'd65335,   16'd65535, 16'h0000, 16'h0100, 16'h0000, 200, 200};
    vecs[6]  = '{1, 32'd900,     16'd1000,  16'h0000, 16'h0100, 16'h0000, 100, 100};
    vecs[7]  = '{0, 32'd900,     16'd1000,  16'h0000, 16'h0100, 16'h0000, 200, 200};
    vecs[8]  = '{0, 32'd900,     16'd1000,  16'h0000, 16'h0100, 16'h0000, 300, 250};
    vecs[9]  = '{1, 32'd900,     16'd1000,  16'h0000, 16'h0000, 16'h0100, 100, 100};
    vecs[10] = '{0, 32'd700,     16'd1000,  16'h0000, 16'h0000, 16'h0100, 200, 200};
    vecs[11] = '{1, 32'd0,       16'd1001,  16'h0080, 16'h0000, 16'h0000, 500, 500};
    vecs[12] = '{1, 32'd999,     16'd1000,  16'h0180, 16'h0000, 16'h0000, 1, 1};
    vecs[13] = '{1, 32'd800,     16'd1000,  16'h0100, 16'h0040, 16'h0080, 350, 350};

    do_reset();
    check("reset busy", bus.busy_o, 0);
    check("reset valid", bus.duty_valid_o, 0);
    check("reset duty", bus.duty_o, 0);

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst) do_reset();
      send(vecs[i].rpm, vecs[i].tgt, vecs[i].kp, vecs[i].ki, vecs[i].kd);
      wait_strobe($sformatf("vec%0d", i), d0, d1);
      check($sformatf("vec%0d duty", i), d0, vecs[i].exp0);
      check($sformatf("vec%0d duty_lim", i), d1, vecs[i].exp1);
      $display("txn vec%0d rpm=%0d tgt=%0d duty=%0d duty_lim=%0d",
               i, vecs[i].rpm, vecs[i].tgt, d0, d1);
    end

    // Second strobe at E+2 is dropped
    do_reset();
    send(32'd400, 16'd1000, 16'h0100, 16'h0000, 16'h0000);
    @(posedge clk); @(negedge clk);
    bus.rpm_data_i = 32'd0; bus.target_rpm_i = 16'd5000; bus.rpm_valid_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rpm_valid_i = 1'b0;
    count_strobes(12, cnt, fk, fd);
    check("drop@E+2 count", cnt, 1);
    check("drop@E+2 time", fk, 3);
    check("drop@E+2 duty", fd, 600);
    $display("txn drop_e2 strobes=%0d duty=%0d", cnt, fd);

    // Strobe at E+4 is dropped
    do_reset();
    send(32'd400, 16'd1000, 16'h0100, 16'h0000, 16'h0000);
    repeat (3) begin @(posedge clk); @(negedge clk); end
    bus.rpm_data_i = 32'd0; bus.target_rpm_i = 16'd5000; bus.rpm_valid_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rpm_valid_i = 1'b0;
    count_strobes(12, cnt, fk, fd);
    check("drop@E+4 count", cnt, 1);
    check("drop@E+4 time", fk, 1);
    check("drop@E+4 duty", fd, 600);
    $display("txn drop_e4 strobes=%0d duty=%0d", cnt, fd);

    // Strobe at E+5 is accepted, result at E+10
    do_reset();
    send(32'd400, 16'd1000, 16'h0100, 16'h0000, 16'h0000);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    bus.rpm_data_i = 32'd0; bus.target_rpm_i = 16'd5000; bus.rpm_valid_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rpm_valid_i = 1'b0;
    check("b2b first valid", bus.duty_valid_o, 1);
    check("b2b first duty", bus.duty_o, 600);
    check("b2b busy", bus.busy_o, 1);
    count_strobes(10, cnt, fk, fd);
    check("b2b count", cnt, 1);
    check("b2b time", fk, 5);
    check("b2b duty", fd, 4095);
    $display("txn back_to_back strobes=%0d duty=%0d", cnt, fd);

    // Enable low mid-update aborts and clears history
    do_reset();
    send(32'd900, 16'd1000, 16'h0000, 16'h0100, 16'h0000);
    wait_strobe("en_pre", d0, d1);
    check("en_pre duty", d0, 100);
    send(32'd900, 16'd1000, 16'h0000, 16'h0100, 16'h0000);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    bus.enable_i = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort busy", bus.busy_o, 0);
    check("abort valid", bus.duty_valid_o, 0);
    check("abort duty", bus.duty_o, 0);
    check("abort duty_lim", bus_lim.duty_o, 0);
    bus.rpm_valid_i = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rpm_valid_i = 1'b0;
    check("disabled sample ignored", bus.busy_o, 0);
    count_strobes(8, cnt, fk, fd);
    check("abort no strobe", cnt, 0);
    bus.enable_i = 1'b1;
    send(32'd900, 16'd1000, 16'h0000, 16'h0100, 16'h0100);
    wait_strobe("en_post", d0, d1);
    check("en_post duty", d0, 200);
    check("en_post duty_lim", d1, 200);
    $display("txn enable_abort duty=%0d", d0);

    // Reset mid-update
    do_reset();
    send(32'd400, 16'd1000, 16'h0100, 16'h0000, 16'h0000);
    wait_strobe("rst_pre", d0, d1);
    check("rst_pre duty", d0, 600);
    send(32'd400, 16'd1000, 16'h0100, 16'h0000, 16'h0000);
    @(posedge clk); @(negedge clk);
    rstn = 1'b0;
    #2;
    check("rst busy", bus.busy_o, 0);
    check("rst valid", bus.duty_valid_o, 0);
    check("rst duty", bus.duty_o, 0);
    @(negedge clk);
    rstn = 1'b1;
    count_strobes(8, cnt, fk, fd);
    check("rst no strobe", cnt, 0);
    $display("txn reset_abort strobes=%0d", cnt);

    // Randomized samples against the reference model
    do_reset();
    for (int n = 0; n < 80; n++) begin
      rpm = 32'($urandom_range(0, 70000));
      if ($urandom_range(0, 3) == 0) tgt = 16'($urandom_range(0, 65535));
      else if (rpm > 65435)          tgt = 16'd65535;
      else                           tgt = 16'(rpm + $urandom_range(0, 200) - 100);
      kp = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
      ki = 16'($urandom_range(0, 63));
      kd = 16'($urandom_range(0, 1023));
      model_step(longint'(rpm), longint'(tgt), longint'(kp), longint'(ki),
                 longint'(kd), y0, y1);
      send(rpm, tgt, kp, ki, kd);
      bus.rpm_data_i = $urandom;
      bus.target_rpm_i = 16'($urandom);
      bus.kp_i = 16'($urandom);
      bus.ki_i = 16'($urandom);
      bus.kd_i = 16'($urandom);
      wait_strobe($sformatf("rnd%0d", n), d0, d1);
      check($sformatf("rnd%0d duty", n), d0, y0);
      check($sformatf("rnd%0d duty_lim", n), d1, y1);
      $display("txn rnd%0d rpm=%0d tgt=%0d kp=%0d ki=%0d kd=%0d duty=%0d duty_lim=%0d",
               n, rpm, tgt, kp, ki, kd, d0, d1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
